// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and step classification for consumers of the Gray counter bus.
package gray_pkg;

  localparam int DEFAULT_W = 4;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_class_e;

  // Prefix XOR from the MSB; zero-extended inputs convert correctly at any narrower width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational W-bit Gray-to-binary converter.
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o[W-1] = gray_i[W-1];

  generate
    for (genvar gi = W - 2; gi >= 0; gi--) begin : g_xor
      assign bin_o[gi] = bin_o[gi+1] ^ gray_i[gi];
    end
  endgenerate

endmodule

// File: rtl/gray_step_monitor.sv
// Samples a Gray counter bus, classifies each change and tracks position, errors and stalls.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int W            = 4,
  parameter int POS_W        = 16,
  parameter int ERR_W        = 8,
  parameter int STALL_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            gray_in,
  input  logic                    clr_pos,
  output logic [W-1:0]            bin_out,
  output logic                    step_valid,
  output logic                    step_up,
  output logic                    err,
  output logic signed [POS_W-1:0] position,
  output logic [ERR_W-1:0]        err_count,
  output logic                    stalled
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic [W-1:0]            new_bin;
  logic [W-1:0]            diff;
  step_class_e             step_class;

  logic [W-1:0]            bin_q, bin_d;
  logic [W-1:0]            base_q, base_d;
  logic                    primed_q, primed_d;
  logic                    step_valid_q, step_valid_d;
  logic                    step_up_q, step_up_d;
  logic                    err_q, err_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    stalled_q, stalled_d;

  gray_to_bin #(.W(W)) u_gray_to_bin (
    .gray_i (gray_in),
    .bin_o  (new_bin)
  );

  // Modulo-2^W difference makes wrap-around steps look like ordinary +/-1.
  assign diff = new_bin - base_q;

  always_comb begin
    step_class = STEP_ILLEGAL;
    if (diff == '0) begin
      step_class = STEP_HOLD;
    end else if (diff == W'(1)) begin
      step_class = STEP_UP;
    end else if (diff == '1) begin
      step_class = STEP_DOWN;
    end
  end

  always_comb begin
    bin_d        = new_bin;
    base_d       = new_bin;
    primed_d     = 1'b1;
    step_valid_d = 1'b0;
    step_up_d    = step_up_q;
    err_d        = 1'b0;
    pos_d        = pos_q;
    err_cnt_d    = err_cnt_q;
    stall_cnt_d  = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;

    // The first sample after reset only establishes the baseline.
    if (primed_q) begin
      unique case (step_class)
        STEP_UP: begin
          step_valid_d = 1'b1;
          step_up_d    = 1'b1;
          stall_cnt_d  = '0;
          if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
        end
        STEP_DOWN: begin
          step_valid_d = 1'b1;
          step_up_d    = 1'b0;
          stall_cnt_d  = '0;
          if (pos_q != POS_MIN) pos_d = pos_q - 1'b1;
        end
        STEP_ILLEGAL: begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end

    if (clr_pos) pos_d = '0;
    stalled_d = (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q        <= '0;
      base_q       <= '0;
      primed_q     <= 1'b0;
      step_valid_q <= 1'b0;
      step_up_q    <= 1'b0;
      err_q        <= 1'b0;
      pos_q        <= '0;
      err_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      stalled_q    <= 1'b0;
    end else begin
      bin_q        <= bin_d;
      base_q       <= base_d;
      primed_q     <= primed_d;
      step_valid_q <= step_valid_d;
      step_up_q    <= step_up_d;
      err_q        <= err_d;
      pos_q        <= pos_d;
      err_cnt_q    <= err_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      stalled_q    <= stalled_d;
    end
  end

  assign bin_out    = bin_q;
  assign step_valid = step_valid_q;
  assign step_up    = step_up_q;
  assign err        = err_q;
  assign position   = pos_q;
  assign err_count  = err_cnt_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed-vector bench for gray_step_monitor with W=4, POS_W=4, STALL_CYCLES=8.
module tb_gray_step_monitor;
  import gray_pkg::*;

  localparam int W     = 4;
  localparam int POS_W = 4;
  localparam int ERR_W = 8;
  localparam int STALL = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [W-1:0]            gray_in = '0;
  logic                    clr_pos = 1'b0;
  logic [W-1:0]            bin_out;
  logic                    step_valid;
  logic                    step_up;
  logic                    err;
  logic signed [POS_W-1:0] position;
  logic [ERR_W-1:0]        err_count;
  logic                    stalled;

  int n_checks = 0;
  int n_fail   = 0;

  gray_step_monitor #(
    .W(W), .POS_W(POS_W), .ERR_W(ERR_W), .STALL_CYCLES(STALL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .clr_pos    (clr_pos),
    .bin_out    (bin_out),
    .step_valid (step_valid),
    .step_up    (step_up),
    .err        (err),
    .position   (position),
    .err_count  (err_count),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample, then look at the registered outputs just after the edge.
  task automatic cycle_bin(input int b, input logic clr);
    logic [MAX_W-1:0] bw;
    bw      = MAX_W'(b & 15);
    gray_in = W'(bin2gray(bw));
    clr_pos = clr;
    @(posedge clk);
    #1;
    clr_pos = 1'b0;
    $display("t=%0t rst=%0b gray=%b clr=%0b -> bin=%0d sv=%0b up=%0b err=%0b pos=%0d errc=%0d stall=%0b",
             $time, rst, gray_in, clr, bin_out, step_valid, step_up, err, position, err_count, stalled);
  endtask

  task automatic check_step(input string tag, input int b, input int sv, input int up, input int pos);
    check_val({tag, ".bin"}, int'(bin_out), b);
    check_val({tag, ".step_valid"}, int'(step_valid), sv);
    check_val({tag, ".step_up"}, int'(step_up), up);
    check_val({tag, ".position"}, int'(position), pos);
  endtask

  initial begin
    rst = 1'b1;
    cycle_bin(9, 1'b0);
    cycle_bin(9, 1'b0);
    check_val("reset.bin", int'(bin_out), 0);
    check_val("reset.step_valid", int'(step_valid), 0);
    check_val("reset.err", int'(err), 0);
    check_val("reset.position", int'(position), 0);
    check_val("reset.err_count", int'(err_count), 0);
    check_val("reset.stalled", int'(stalled), 0);
    rst = 1'b0;

    // Hold at zero: baseline cycle plus four holds, no pulses.
    for (int i = 0; i < 5; i++) begin
      cycle_bin(0, 1'b0);
      check_val("hold.step_valid", int'(step_valid), 0);
      check_val("hold.err", int'(err), 0);
    end
    check_step("hold", 0, 0, 0, 0);
    check_val("hold.stalled", int'(stalled), 0);

    // Gray 0001,0011,0010,0110 -> bin 1..4.
    for (int i = 1; i <= 4; i++) begin
      cycle_bin(i, 1'b0);
      check_step("up", i, 1, 1, i);
    end

    // Wrap: prime at bin 15, then 15->0 up, 0->15 down.
    rst = 1'b1;
    cycle_bin(0, 1'b0);
    rst = 1'b0;
    cycle_bin(15, 1'b0);
    check_step("wrap.prime", 15, 0, 0, 0);
    cycle_bin(0, 1'b0);
    check_step("wrap.up", 0, 1, 1, 1);
    cycle_bin(15, 1'b0);
    check_step("wrap.down", 15, 1, 0, 0);

    // 15->0 legal up, then 0->7 illegal, then 7->8 legal up.
    cycle_bin(0, 1'b0);
    check_step("pre_illegal", 0, 1, 1, 1);
    cycle_bin(7, 1'b0);
    check_step("illegal", 7, 0, 1, 1);
    check_val("illegal.err", int'(err), 1);
    check_val("illegal.err_count", int'(err_count), 1);
    cycle_bin(8, 1'b0);
    check_step("resync", 8, 1, 1, 2);
    check_val("resync.err", int'(err), 0);
    check_val("resync.err_count", int'(err_count), 1);

    // Ten up steps from position 2 saturate at +7.
    for (int i = 1; i <= 10; i++) begin
      cycle_bin(8 + i, 1'b0);
      check_val("sat.step_valid", int'(step_valid), 1);
      check_val("sat.position", int'(position), (2 + i > 7) ? 7 : 2 + i);
    end
    // Clear on the same cycle as a step.
    cycle_bin(19, 1'b1);
    check_step("clr_step", 3, 1, 1, 0);

    // Stall: seven holds not enough, eighth asserts.
    for (int i = 1; i <= 7; i++) begin
      cycle_bin(19, 1'b0);
      check_val("stall.pre", int'(stalled), 0);
    end
    cycle_bin(19, 1'b0);
    check_val("stall.set", int'(stalled), 1);
    cycle_bin(18, 1'b0);
    check_step("stall.step", 2, 1, 0, -1);
    check_val("stall.clear", int'(stalled), 0);

    // Reset mid-sequence, then the first sample must not count as a step.
    rst = 1'b1;
    cycle_bin(6, 1'b0);
    check_step("midrst", 0, 0, 0, 0);
    check_val("midrst.err_count", int'(err_count), 0);
    check_val("midrst.stalled", int'(stalled), 0);
    rst = 1'b0;
    cycle_bin(5, 1'b0);
    check_step("midrst.prime", 5, 0, 0, 0);
    check_val("midrst.prime_err", int'(err), 0);
    cycle_bin(6, 1'b0);
    check_step("midrst.step", 6, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
